// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request load/store responder for a word-wide synchronous data RAM
module mem_access_unit #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_bit_ext,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, ACK} state_t;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  state_t      state;
  logic        r_we;
  logic        r_ext;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic        req_err;
  logic        sub_word;
  logic [4:0]  sh;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merge_val;
  logic        unused_addr;

  assign unused_addr = ^cpu_addr[31:ADDR_WIDTH+2];

  // request legality plus the lane extract (loads) and lane merge (sub-word stores) from the latched request
  always_comb begin
    req_err   = cpu_size == 2'b11 || (cpu_size == SZ_HALF && cpu_addr[0]) || (cpu_size == SZ_WORD && cpu_addr[1:0] != 2'b00);
    sub_word  = cpu_size != SZ_WORD;
    sh        = {r_off, 3'b000};
    b_lane    = 8'(ram_rdata >> sh);
    h_lane    = r_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_val  = r_size == SZ_BYTE ? (r_ext ? {24'h0, b_lane} : {{24{b_lane[7]}}, b_lane})
              : r_size == SZ_HALF ? (r_ext ? {16'h0, h_lane} : {{16{h_lane[15]}}, h_lane})
              : ram_rdata;
    lane_mask = (r_size == SZ_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merge_val = (ram_rdata & ~lane_mask) | ((r_wdata << sh) & lane_mask);
  end

  // sequence one request through the RAM; every output is a register so reset clears them at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_ext     <= 1'b0;
      r_size    <= SZ_WORD;
      r_off     <= 2'b00;
      r_wdata   <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      busy      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          r_we     <= cpu_we;
          r_ext    <= cpu_bit_ext;
          r_size   <= cpu_size;
          r_off    <= cpu_addr[1:0];
          r_wdata  <= cpu_wdata;
          ram_addr <= cpu_addr[ADDR_WIDTH+1:2];
          busy     <= 1'b1;
          if (req_err) begin
            state     <= ACK;
            cpu_ack   <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else if (cpu_we && !sub_word) begin
            state     <= WR;
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_wdata <= cpu_wdata;
          end else begin
            state  <= RD_REQ;
            ram_en <= 1'b1;
            ram_we <= 1'b0;
          end
        end
        RD_REQ: begin
          state  <= RD_WAIT;
          ram_en <= 1'b0;
        end
        RD_WAIT: if (r_we) begin
          state     <= WR;
          ram_en    <= 1'b1;
          ram_we    <= 1'b1;
          ram_wdata <= merge_val;
        end else begin
          state     <= ACK;
          cpu_ack   <= 1'b1;
          cpu_rdata <= load_val;
        end
        WR: begin
          state     <= ACK;
          ram_en    <= 1'b0;
          ram_we    <= 1'b0;
          cpu_ack   <= 1'b1;
          cpu_rdata <= '0;
        end
        ACK: begin
          state     <= IDLE;
          cpu_ack   <= 1'b0;
          cpu_err   <= 1'b0;
          busy      <= 1'b0;
          cpu_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed load/store checks against a byte-addressed memory model
module tb_mem_access_unit;
  localparam int AW = 11;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic          cpu_bit_ext = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [1:0]    cpu_size = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ack;
  logic          cpu_err;
  logic          busy;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   ram [2**AW] = '{default: '0};
  logic [7:0]    mb [4*2**AW] = '{default: '0};
  int            n_tests = 0;
  int            n_fail = 0;
  int            n_rd = 0;
  int            n_wr = 0;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_bit_ext(cpu_bit_ext),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // synchronous data RAM with access counters
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      ram[ram_addr] <= ram_wdata;
      n_wr <= n_wr + 1;
    end
    if (ram_en && !ram_we) begin
      ram_rdata <= ram[ram_addr];
      n_rd <= n_rd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 4 : sz == 2'd1 ? 2 : 1;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] sz);
    return sz == 2'd3 || (int'(a[AW+1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic ext);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[int'(a[AW+1:0]) + i]) << (8 * i));
    if (!ext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    for (int i = 0; i < nbytes(sz); i++) mb[int'(a[AW+1:0]) + i] = wd[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  task automatic run_op(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                        input logic ext, input string tag, output logic [31:0] got);
    bit err;
    int w, n, exp_lat, exp_rds, exp_wrs, lat, bad_busy, bad_addr, rd0, wr0;
    logic [31:0] exp_rd;
    err = is_err(a, sz);
    w = int'(a[AW+1:2]);
    n = nbytes(sz);
    exp_lat = err ? 1 : !we ? 3 : n == 4 ? 2 : 4;
    exp_rds = (err || (we && n == 4)) ? 0 : 1;
    exp_wrs = (!err && we) ? 1 : 0;
    exp_rd = '0;
    if (!err && !we) exp_rd = model_load(a, sz, ext);
    if (!err && we) model_store(a, wd, sz);
    lat = 0;
    bad_busy = 0;
    bad_addr = 0;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_size = sz;
    cpu_bit_ext = ext;
    rd0 = n_rd;
    wr0 = n_wr;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'($urandom);
    cpu_addr = $urandom;
    cpu_wdata = $urandom;
    cpu_size = 2'($urandom);
    cpu_bit_ext = 1'($urandom);
    do begin
      @(negedge clk);
      lat++;
      if (!busy) bad_busy++;
      if (ram_addr != AW'(w)) bad_addr++;
    end while (!cpu_ack && lat < 8);
    got = cpu_rdata;
    check({tag, " ack"}, 32'(cpu_ack), 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, 32'(cpu_err), 32'(err));
    check({tag, " rdata"}, cpu_rdata, exp_rd);
    check({tag, " ram reads"}, n_rd - rd0, exp_rds);
    check({tag, " ram writes"}, n_wr - wr0, exp_wrs);
    check({tag, " busy low"}, bad_busy, 0);
    check({tag, " ram_addr moved"}, bad_addr, 0);
    check({tag, " ram word"}, ram[w], model_word(w));
    @(negedge clk);
    check({tag, " idle"}, {30'b0, busy, cpu_ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, a, exp_a, exp_c;
    logic [1:0] sz;
    int rd0, wr0, acks;
    repeat (2) @(negedge clk);
    check("reset ctl", {27'b0, cpu_ack, cpu_err, busy, ram_en, ram_we}, 32'd0);
    check("reset rdata", cpu_rdata, 32'd0);
    check("reset ram_addr", 32'(ram_addr), 32'd0);
    check("reset ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    for (int w = 0; w < 64; w++) run_op(1'b1, 32'(4 * w), $urandom, 2'd0, 1'b0, "preload", got);
    run_op(1'b1, 32'h40, 32'hDEAD_BEEF, 2'd0, 1'b0, "sw", got);
    check("sw ram16", ram[16], 32'hDEAD_BEEF);
    run_op(1'b0, 32'h40, 32'h0, 2'd0, 1'b1, "lw", got);
    check("lw value", got, 32'hDEAD_BEEF);
    run_op(1'b1, 32'h40, 32'h80FF_7F01, 2'd0, 1'b0, "sw2", got);
    run_op(1'b0, 32'h42, 32'h0, 2'd2, 1'b0, "lb sx", got);
    check("lb 0x42 sx", got, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h42, 32'h0, 2'd2, 1'b1, "lb zx", got);
    check("lb 0x42 zx", got, 32'h0000_00FF);
    run_op(1'b0, 32'h43, 32'h0, 2'd2, 1'b0, "lb sx3", got);
    check("lb 0x43 sx", got, 32'hFFFF_FF80);
    run_op(1'b1, 32'h40, 32'h1122_3344, 2'd0, 1'b0, "sw3", got);
    run_op(1'b1, 32'h42, 32'h0000_ABCD, 2'd1, 1'b0, "sh", got);
    check("sh ram16", ram[16], 32'hABCD_3344);
    run_op(1'b0, 32'h42, 32'h0, 2'd1, 1'b0, "lh", got);
    check("lh 0x42 sx", got, 32'hFFFF_ABCD);
    run_op(1'b0, 32'h41, 32'h0, 2'd0, 1'b0, "err lw", got);
    run_op(1'b1, 32'h43, 32'h1234, 2'd1, 1'b0, "err sh", got);
    run_op(1'b0, 32'h40, 32'h0, 2'd3, 1'b0, "err size", got);
    check("err ram16", ram[16], 32'hABCD_3344);
    @(negedge clk);
    exp_a = model_load(32'h80, 2'd0, 1'b0);
    exp_c = model_load(32'h94, 2'd0, 1'b0);
    rd0 = n_rd;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_size = 2'd0;
    cpu_bit_ext = 1'b0;
    cpu_addr = 32'h80;
    @(posedge clk);
    #1 cpu_addr = 32'h84;
    @(negedge clk);
    check("gate c1 busy", 32'(busy), 32'd1);
    check("gate c1 addr", 32'(ram_addr), 32'd32);
    @(posedge clk);
    #1 cpu_addr = 32'h88;
    @(negedge clk);
    check("gate c2 addr", 32'(ram_addr), 32'd32);
    @(posedge clk);
    #1 cpu_addr = 32'h94;
    @(negedge clk);
    check("gate c3 ack", 32'(cpu_ack), 32'd1);
    check("gate c3 rdata", cpu_rdata, exp_a);
    @(negedge clk);
    check("gate c4 idle", {30'b0, busy, cpu_ack}, 32'd0);
    check("gate reads", n_rd - rd0, 1);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    check("gate second busy", 32'(busy), 32'd1);
    check("gate second addr", 32'(ram_addr), 32'd37);
    repeat (2) @(negedge clk);
    check("gate second ack", 32'(cpu_ack), 32'd1);
    check("gate second rdata", cpu_rdata, exp_c);
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 32'h40;
    cpu_wdata = 32'h5A;
    cpu_size = 2'd2;
    wr0 = n_wr;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort ctl", {27'b0, cpu_ack, cpu_err, busy, ram_en, ram_we}, 32'd0);
    check("abort rdata", cpu_rdata, 32'd0);
    check("abort ram_addr", 32'(ram_addr), 32'd0);
    check("abort ram_wdata", ram_wdata, 32'd0);
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      acks += int'(cpu_ack);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(cpu_ack);
    end
    check("abort no ack", acks, 0);
    check("abort no write", n_wr - wr0, 0);
    check("abort ram16", ram[16], 32'hABCD_3344);
    run_op(1'b0, 32'h40, 32'h0, 2'd0, 1'b0, "post rst lw", got);
    check("post rst value", got, 32'hABCD_3344);
    for (int i = 0; i < 300; i++) begin
      a = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_op(1'($urandom), a, $urandom, sz, 1'($urandom), "rand", got);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
